tracker_axis_ctrl: RTL and testbench

- Parametrised multi-axis motor-direction controller for the tracking mount.
- Replaces the fixed two-axis, single-threshold comparator with a per-axis FSM that adds deadband/hysteresis, dead time on reversal, run timeout with sticky fault, and per-axis enable.
- Each axis runs in one of two modes: AUTO balances a light-sensor pair; MANUAL drives the position toward the setpoint.
- Sits between the sensor/angle input registers and the H-bridge drive pins.

---
 rtl/tracker_axis_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_tracker_axis_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tracker_axis_ctrl.sv
// tracker_axis_ctrl: multi-axis motor-direction controller for the tracking mount.
// Each axis computes a registered signed error (sensor balance in AUTO, setpoint
// minus position in MANUAL) and runs an independent FSM with a deadband for starting
// a move, a tighter stop band for ending it, dead time after every run, and a run
// timeout that latches a sticky fault until fault_clr is pulsed.
// Optional feature macro: TRACKER_LIMIT_SW_EN adds the lim_pos/lim_neg end-stop inputs.
// All outputs are flops loaded from the next-state decode, so a drive pin never glitches.

module tracker_axis_ctrl #(
    parameter int NUM_AXES       = 2,
    parameter int W              = 16,
    parameter int DEADBAND       = 8,
    parameter int STOP_BAND      = 2,
    parameter int DEAD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [NUM_AXES-1:0]   axis_en,
    input  logic [NUM_AXES*W-1:0] sensor_a,
    input  logic [NUM_AXES*W-1:0] sensor_b,
    input  logic [NUM_AXES*W-1:0] setpoint,
    input  logic [NUM_AXES*W-1:0] position,
    input  logic                  fault_clr,
    output logic [NUM_AXES-1:0]   drive_pos,
    output logic [NUM_AXES-1:0]   drive_neg,
    output logic [NUM_AXES-1:0]   busy,
    output logic [NUM_AXES-1:0]   fault
`ifdef TRACKER_LIMIT_SW_EN
    ,
    input  logic [NUM_AXES-1:0]   lim_pos,
    input  logic [NUM_AXES-1:0]   lim_neg
`endif
);

    // Error is one bit wider than the inputs so the difference of two unsigned
    // W-bit words always fits without saturation.
    localparam int EW = W + 1;
    // Counter widths leave headroom for the terminal value itself.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam int BW = $clog2(DEAD_CYCLES + 2);

    localparam logic signed [EW-1:0] DB_POS = EW'(DEADBAND);
    localparam logic signed [EW-1:0] DB_NEG = -DB_POS;
    localparam logic signed [EW-1:0] SB_POS = EW'(STOP_BAND);
    localparam logic signed [EW-1:0] SB_NEG = -SB_POS;
    localparam logic [CW-1:0]        RUN_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [BW-1:0]        BRK_LAST = BW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0]        RUN_MAX  = {CW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN_POS = 3'd1,
        ST_RUN_NEG = 3'd2,
        ST_BRAKE   = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
        logic signed [EW-1:0] err_s;
        logic signed [EW-1:0] err_q_r;
        state_t               state_r;
        state_t               state_s;
        logic [CW-1:0]        run_cnt_r;
        logic [BW-1:0]        brk_cnt_r;
        logic                 mode_lat_r;
        logic                 timeout_s;
        logic                 mode_chg_s;
        logic                 lim_pos_s;
        logic                 lim_neg_s;
        logic                 run_s;
        logic                 run_r;
        logic                 drv_pos_r;
        logic                 drv_neg_r;
        logic                 busy_r;
        logic                 fault_r;

`ifdef TRACKER_LIMIT_SW_EN
        assign lim_pos_s = lim_pos[i];
        assign lim_neg_s = lim_neg[i];
`else
        assign lim_pos_s = 1'b0;
        assign lim_neg_s = 1'b0;
`endif

        assign timeout_s  = (run_cnt_r >= RUN_LAST);
        assign mode_chg_s = (mode != mode_lat_r);
        assign run_s      = (state_s == ST_RUN_POS) || (state_s == ST_RUN_NEG);
        assign run_r      = (state_r == ST_RUN_POS) || (state_r == ST_RUN_NEG);

        // Signed error selected by the global mode; zero-extend before subtracting.
        always_comb begin
            if (mode) begin
                err_s = $signed({1'b0, sensor_a[i*W +: W]}) - $signed({1'b0, sensor_b[i*W +: W]});
            end else begin
                err_s = $signed({1'b0, setpoint[i*W +: W]}) - $signed({1'b0, position[i*W +: W]});
            end
        end

        // Next-state decode: timeout beats limits, limits beat the error/enable/mode exits.
        always_comb begin
            state_s = state_r;
            case (state_r)
                ST_IDLE: begin
                    if (axis_en[i] && (err_q_r > DB_POS) && !lim_pos_s) begin
                        state_s = ST_RUN_POS;
                    end else if (axis_en[i] && (err_q_r < DB_NEG) && !lim_neg_s) begin
                        state_s = ST_RUN_NEG;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN_POS: begin
                    if (timeout_s) begin
                        state_s = ST_FAULT;
                    end else if (lim_pos_s) begin
                        state_s = ST_BRAKE;
                    end else if ((err_q_r <= SB_POS) || !axis_en[i] || mode_chg_s) begin
                        // Overshoot past -DEADBAND also lands here: never reverse directly.
                        state_s = ST_BRAKE;
                    end else begin
                        state_s = ST_RUN_POS;
                    end
                end
                ST_RUN_NEG: begin
                    if (timeout_s) begin
                        state_s = ST_FAULT;
                    end else if (lim_neg_s) begin
                        state_s = ST_BRAKE;
                    end else if ((err_q_r >= SB_NEG) || !axis_en[i] || mode_chg_s) begin
                        state_s = ST_BRAKE;
                    end else begin
                        state_s = ST_RUN_NEG;
                    end
                end
                ST_BRAKE: begin
                    if (brk_cnt_r >= BRK_LAST) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_BRAKE;
                    end
                end
                ST_FAULT: begin
                    // Clearing a fault still passes through BRAKE for dead time.
                    if (fault_clr) begin
                        state_s = ST_BRAKE;
                    end else begin
                        state_s = ST_FAULT;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        // Error register, state register, counters, mode latch and registered outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                err_q_r    <= '0;
                state_r    <= ST_IDLE;
                run_cnt_r  <= '0;
                brk_cnt_r  <= '0;
                mode_lat_r <= 1'b0;
                drv_pos_r  <= 1'b0;
                drv_neg_r  <= 1'b0;
                busy_r     <= 1'b0;
                fault_r    <= 1'b0;
            end else begin
                err_q_r <= err_s;
                state_r <= state_s;

                if (run_s && !run_r) begin
                    run_cnt_r  <= '0;
                    mode_lat_r <= mode;
                end else if (run_r && (run_cnt_r != RUN_MAX)) begin
                    run_cnt_r  <= run_cnt_r + CW'(1);
                    mode_lat_r <= mode_lat_r;
                end else begin
                    run_cnt_r  <= run_cnt_r;
                    mode_lat_r <= mode_lat_r;
                end

                if ((state_s == ST_BRAKE) && (state_r != ST_BRAKE)) begin
                    brk_cnt_r <= '0;
                end else if (state_r == ST_BRAKE) begin
                    brk_cnt_r <= brk_cnt_r + BW'(1);
                end else begin
                    brk_cnt_r <= brk_cnt_r;
                end

                drv_pos_r <= (state_s == ST_RUN_POS);
                drv_neg_r <= (state_s == ST_RUN_NEG);
                busy_r    <= (state_s != ST_IDLE);
                fault_r   <= (state_s == ST_FAULT);
            end
        end

        assign drive_pos[i] = drv_pos_r;
        assign drive_neg[i] = drv_neg_r;
        assign busy[i]      = busy_r;
        assign fault[i]     = fault_r;
    end

endmodule

// File: tb/tb_tracker_axis_ctrl.sv
// Testbench for tracker_axis_ctrl: directed scenarios followed by randomized input
// segments, all compared every cycle against a behavioural per-axis model built from
// the controller's rules (direction, remaining dead time, sticky fault, run length).
// Optional feature macro: TRACKER_LIMIT_SW_EN also drives and models the end stops.

module tb_tracker_axis_ctrl;

    localparam int NA = 2;
    localparam int W  = 16;
    localparam int DB = 8;
    localparam int SB = 2;
    localparam int DC = 4;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mode = 1'b0;
    logic [NA-1:0]   axis_en = '0;
    logic [NA*W-1:0] sensor_a = '0;
    logic [NA*W-1:0] sensor_b = '0;
    logic [NA*W-1:0] setpoint = '0;
    logic [NA*W-1:0] position = '0;
    logic            fault_clr = 1'b0;
    logic [NA-1:0]   drive_pos;
    logic [NA-1:0]   drive_neg;
    logic [NA-1:0]   busy;
    logic [NA-1:0]   fault;
`ifdef TRACKER_LIMIT_SW_EN
    logic [NA-1:0]   lim_pos = '0;
    logic [NA-1:0]   lim_neg = '0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model: dir +1/-1/0, dead-time cycles left, sticky fault, run length.
    int m_err [NA];
    int m_dir [NA];
    int m_brk [NA];
    int m_run [NA];
    bit m_flt [NA];
    bit m_mlat[NA];

    tracker_axis_ctrl #(
        .NUM_AXES(NA), .W(W), .DEADBAND(DB), .STOP_BAND(SB),
        .DEAD_CYCLES(DC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .axis_en(axis_en),
        .sensor_a(sensor_a), .sensor_b(sensor_b),
        .setpoint(setpoint), .position(position),
        .fault_clr(fault_clr),
        .drive_pos(drive_pos), .drive_neg(drive_neg),
        .busy(busy), .fault(fault)
`ifdef TRACKER_LIMIT_SW_EN
        , .lim_pos(lim_pos), .lim_neg(lim_neg)
`endif
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit lim_p(int i);
`ifdef TRACKER_LIMIT_SW_EN
        return lim_pos[i];
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit lim_n(int i);
`ifdef TRACKER_LIMIT_SW_EN
        return lim_neg[i];
`else
        return 1'b0;
`endif
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        int e;
        int ua, ub;
        bit lim_hit;
        bit err_done;
        for (int i = 0; i < NA; i++) begin
            if (rst) begin
                m_err[i] = 0; m_dir[i] = 0; m_brk[i] = 0;
                m_run[i] = 0; m_flt[i] = 1'b0; m_mlat[i] = 1'b0;
            end else begin
                e = m_err[i];
                if (m_flt[i]) begin
                    if (fault_clr) begin
                        m_flt[i] = 1'b0;
                        m_brk[i] = DC;
                    end
                end else if (m_brk[i] > 0) begin
                    m_brk[i]--;
                end else if (m_dir[i] != 0) begin
                    m_run[i]++;
                    lim_hit  = (m_dir[i] > 0) ? lim_p(i) : lim_n(i);
                    err_done = (m_dir[i] > 0) ? (e <= SB) : (e >= -SB);
                    if (m_run[i] >= TO) begin
                        m_dir[i] = 0;
                        m_flt[i] = 1'b1;
                    end else if (lim_hit || !axis_en[i] || (mode != m_mlat[i]) || err_done) begin
                        m_dir[i] = 0;
                        m_brk[i] = DC;
                    end
                end else if (axis_en[i]) begin
                    if (e > DB && !lim_p(i)) begin
                        m_dir[i] = 1; m_run[i] = 0; m_mlat[i] = mode;
                    end else if (e < -DB && !lim_n(i)) begin
                        m_dir[i] = -1; m_run[i] = 0; m_mlat[i] = mode;
                    end
                end
                if (mode) begin
                    ua = sensor_a[i*W +: W];
                    ub = sensor_b[i*W +: W];
                end else begin
                    ua = setpoint[i*W +: W];
                    ub = position[i*W +: W];
                end
                m_err[i] = ua - ub;
            end
        end
    endtask

    task automatic compare_model();
        logic [NA-1:0] ep, en, eb, ef;
        for (int i = 0; i < NA; i++) begin
            ep[i] = (m_dir[i] == 1);
            en[i] = (m_dir[i] == -1);
            eb[i] = (m_dir[i] != 0) || (m_brk[i] > 0) || m_flt[i];
            ef[i] = m_flt[i];
        end
        check("drive_pos", 32'(drive_pos), 32'(ep));
        check("drive_neg", 32'(drive_neg), 32'(en));
        check("busy", 32'(busy), 32'(eb));
        check("fault", 32'(fault), 32'(ef));
        check("no_shoot_through", 32'(drive_pos & drive_neg), 32'd0);
    endtask

    // One clock: edge, model update, then sample on the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_model();
    endtask

    task automatic set_manual(input int ax, input int sp, input int pos);
        setpoint[ax*W +: W] = W'(sp);
        position[ax*W +: W] = W'(pos);
    endtask

    task automatic set_auto(input int ax, input int a, input int b);
        sensor_a[ax*W +: W] = W'(a);
        sensor_b[ax*W +: W] = W'(b);
    endtask

    // From a BRAKE sample, count the remaining dead-time and idle samples until axis 0 drives positive.
    task automatic measure_gap(input string tag);
        int nb = 1;
        int ni = 0;
        int guard = 0;
        while (!drive_pos[0] && guard < 20) begin
            step();
            guard++;
            if (!drive_pos[0]) begin
                if (busy[0]) nb++;
                else ni++;
            end
        end
        check({tag, "_brake_cycles"}, 32'(nb), 32'(DC));
        check({tag, "_idle_cycles"}, 32'(ni), 32'd1);
        check({tag, "_restart"}, 32'(drive_pos[0]), 32'd1);
    endtask

    initial begin
        int run_len;
        int guard;
        int seg_len;

        // Reset: all outputs low.
        step();
        step();
        check("reset_outputs", 32'({drive_pos, drive_neg, busy, fault}), 32'd0);
        rst = 1'b0;

        // AUTO start and stop on axis 0.
        mode = 1'b1;
        axis_en = 2'b01;
        set_auto(0, 100, 91);
        step();
        check("auto_latency", 32'(drive_pos[0]), 32'd0);
        step();
        check("auto_start", 32'(drive_pos[0]), 32'd1);
        set_auto(0, 100, 98);
        step();
        check("auto_stop_latency", 32'(drive_pos[0]), 32'd1);
        step();
        check("auto_stop", 32'(drive_pos[0]), 32'd0);
        check("auto_brake_busy", 32'(busy[0]), 32'd1);
        repeat (3) step();
        check("auto_brake_last", 32'(busy[0]), 32'd1);
        step();
        check("auto_idle", 32'(busy[0]), 32'd0);

        // Deadband boundary in MANUAL.
        mode = 1'b0;
        set_manual(0, 108, 100);
        repeat (6) step();
        check("deadband_equal", 32'({drive_pos[0], busy[0]}), 32'd0);
        set_manual(0, 108, 99);
        step();
        step();
        check("deadband_exceed", 32'(drive_pos[0]), 32'd1);

        // Overshoot: positive run sees a large negative error, brakes, then runs negative.
        set_manual(0, 60, 99);
        repeat (8) step();
        check("overshoot_neg_run", 32'(drive_neg[0]), 32'd1);
        set_manual(0, 140, 99);
        step();
        step();
        check("overshoot_drop", 32'({drive_pos[0], drive_neg[0]}), 32'd0);
        measure_gap("overshoot");

        // Timeout: hold a positive error until the axis faults.
        set_manual(0, 120, 100);
        run_len = 1;
        guard = 0;
        while (!fault[0] && guard < 200) begin
            step();
            guard++;
            if (drive_pos[0]) run_len++;
        end
        check("timeout_fault", 32'(fault[0]), 32'd1);
        check("timeout_run_len", 32'(run_len), 32'(TO));
        check("timeout_drives", 32'({drive_pos[0], drive_neg[0]}), 32'd0);
        repeat (3) step();
        check("fault_sticky", 32'(fault[0]), 32'd1);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("fault_cleared", 32'({fault[0], busy[0]}), 32'b01);
        measure_gap("fault_clr");

        // Independence: axis 1 runs negative, then is disabled alone.
        axis_en = 2'b11;
        set_manual(1, 100, 130);
        repeat (3) step();
        check("indep_both_run", 32'({drive_pos[0], drive_neg[1]}), 32'b11);
        axis_en = 2'b01;
        step();
        check("indep_axis1_brake", 32'({drive_neg[1], busy[1]}), 32'b01);
        check("indep_axis0_runs", 32'(drive_pos[0]), 32'd1);
        rst = 1'b1;
        step();
        check("reset_mid_run", 32'({drive_pos, drive_neg, busy, fault}), 32'd0);

        // Mode change during a positive run brakes even with a large error.
        rst = 1'b0;
        axis_en = 2'b11;
        set_auto(0, 130, 100);
        repeat (3) step();
        check("mode_run", 32'(drive_pos[0]), 32'd1);
        mode = 1'b1;
        step();
        check("mode_change_brake", 32'({drive_pos[0], busy[0]}), 32'b01);
        repeat (8) step();

        // Randomized segments: inputs held for random lengths so timeouts also occur.
        for (int s = 0; s < 60; s++) begin
            mode    = ($urandom_range(0, 5) == 0) ? ~mode : mode;
            axis_en = ($urandom_range(0, 3) == 0) ? NA'($urandom) : axis_en;
            rst     = ($urandom_range(0, 29) == 0);
            fault_clr = ($urandom_range(0, 2) == 0);
            for (int i = 0; i < NA; i++) begin
                set_auto(i, 1000 + $urandom_range(0, 40), 1020);
                set_manual(i, 500 + $urandom_range(0, 40), 520);
            end
`ifdef TRACKER_LIMIT_SW_EN
            for (int i = 0; i < NA; i++) begin
                lim_pos[i] = ($urandom_range(0, 7) == 0);
                lim_neg[i] = ($urandom_range(0, 7) == 0);
            end
`endif
            step();
            rst = 1'b0;
            fault_clr = 1'b0;
            seg_len = $urandom_range(1, 90);
            repeat (seg_len) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
